mac_dot_ctrl: RTL and testbench

//  Sequencer wrapping one 8x8->16 MAC unit (product registered into a 16-bit accumulator every clk;
//  en=0 loads prod, en=1 adds prod). Accepts a start command with vector length L.

---
 rtl/mac_dot_ctrl.sv | 126 ++++++++++++
 tb/tb_mac_dot_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_ctrl.sv
// rtl/mac_dot_ctrl.sv - dot-product sequencer driving an external 8x8->16 MAC unit
module mac_dot_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             mac_en,
    output logic [7:0]       mac_a,
    output logic [7:0]       mac_b,
    input  logic [15:0]      mac_c
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CAPT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [LEN_W-1:0] cnt;
    logic             beat;
    logic             last_beat;
    logic             res_take;
    logic             cmd_go;
    logic             cmd_empty;

    // Handshake qualifiers shared by the FSM and the datapath registers.
    assign beat      = in_valid & in_ready;
    assign last_beat = beat && (cnt == LEN_W'(1));
    assign res_take  = res_valid & res_ready;
    assign cmd_go    = (state == ST_IDLE) && start && (len != '0);
    assign cmd_empty = (state == ST_IDLE) && start && (len == '0);

    // Next-state decode; start is only looked at in IDLE so it never queues.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cmd_go) begin
                    state_nxt = ST_RUN;
                end else if (cmd_empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_beat) begin
                    state_nxt = ST_CAPT;
                end
            end
            ST_CAPT: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (res_take) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Remaining-beat counter: loaded with the command length, one down per beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cmd_go) begin
            cnt <= len;
        end else if (beat) begin
            cnt <= cnt - LEN_W'(1);
        end
    end

    // Result register: the MAC output is final during CAPT; empty commands yield 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_data <= 16'd0;
        end else if (cmd_empty) begin
            res_data <= 16'd0;
        end else if (state == ST_CAPT) begin
            res_data <= mac_c;
        end
    end

    // Result valid rises on the first DONE cycle and drops on the consuming handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
        end else if (state == ST_DONE) begin
            res_valid <= !res_take;
        end else begin
            res_valid <= 1'b0;
        end
    end

    // Status and operand-side handshake.
    assign busy     = (state != ST_IDLE);
    assign in_ready = (state == ST_RUN);

    // MAC drive: IDLE loads a zero product (clears the accumulator), every other
    // state accumulates, and anything but an accepted beat contributes zero.
    assign mac_en = (state != ST_IDLE);
    assign mac_a  = beat ? in_a : 8'd0;
    assign mac_b  = beat ? in_b : 8'd0;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// tb/tb_mac_dot_ctrl.sv - randomized and directed checks of mac_dot_ctrl against a dot-product model
module tb_mac_dot_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        mac_en;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic [15:0] mac_c;

    int vectors;
    int miscompares;
    int edge_cnt;
    int last_res;

    logic [7:0] a_arr [256];
    logic [7:0] b_arr [256];

    mac_dot_ctrl #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment MAC: en=0 loads the product, en=1 adds it; cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_c <= 16'd0;
        end else if (mac_en) begin
            mac_c <= mac_c + ({8'd0, mac_a} * {8'd0, mac_b});
        end else begin
            mac_c <= {8'd0, mac_a} * {8'd0, mac_b};
        end
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full command, entered and left at a negedge with the DUT idle.
    // mode 0: no stalls, 1: three stall cycles between beats, 2: random stalls.
    task automatic run_cmd(input int n, input int mode, input int hold);
        int exp_sum;
        int stalls;
        int idx;
        int gap;
        int guard;
        int start_edge;
        logic v;
        exp_sum = 0;
        for (int i = 0; i < n; i++) exp_sum += int'(a_arr[i]) * int'(b_arr[i]);
        exp_sum = exp_sum % 65536;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mac_en", 32'(mac_en), 32'd0);
        start = 1'b1;
        len = 8'(n);
        start_edge = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        len = 8'($urandom_range(1, 255));
        idx = 0;
        stalls = 0;
        gap = 0;
        guard = 0;
        while (idx < n && guard < 4000) begin
            if (mode == 1) v = (gap == 0);
            else if (mode == 2) v = ($urandom_range(0, 3) != 0);
            else v = 1'b1;
            in_valid = v;
            in_a = v ? a_arr[idx] : 8'($urandom);
            in_b = v ? b_arr[idx] : 8'($urandom);
            #1;
            chk("run_in_ready", 32'(in_ready), 32'd1);
            chk("run_mac_en", 32'(mac_en), 32'd1);
            chk("run_mac_a", 32'(mac_a), v ? 32'(a_arr[idx]) : 32'd0);
            chk("run_mac_b", 32'(mac_b), v ? 32'(b_arr[idx]) : 32'd0);
            @(negedge clk);
            if (v) begin
                idx++;
                gap = 3;
            end else begin
                stalls++;
                if (gap > 0) gap--;
            end
            guard++;
        end
        chk("beats_taken", 32'(idx), 32'(n));
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        guard = 0;
        while (res_valid !== 1'b1 && guard < 20) begin
            #1;
            chk("post_in_ready", 32'(in_ready), 32'd0);
            chk("post_mac_a", 32'(mac_a), 32'd0);
            chk("post_busy", 32'(busy), 32'd1);
            @(negedge clk);
            guard++;
        end
        chk("res_valid_rise", 32'(res_valid), 32'd1);
        chk("latency", 32'(edge_cnt - start_edge), (n == 0) ? 32'd1 : 32'(n + 2 + stalls));
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0;
            if (h == 1) start = 1'b1;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", 32'(res_data), 32'(exp_sum));
            chk("hold_mac_en", 32'(mac_en), 32'd1);
            @(negedge clk);
            start = 1'b0;
        end
        res_ready = 1'b1;
        chk("res_data", 32'(res_data), 32'(exp_sum));
        last_res = int'(res_data);
        @(negedge clk);
        res_ready = 1'b0;
        chk("after_valid", 32'(res_valid), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        edge_cnt = 0;
        last_res = 0;
        rst = 1'b1;
        start = 1'b0;
        len = 8'd0;
        in_valid = 1'b0;
        in_a = 8'd0;
        in_b = 8'd0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: len=4, no stalls
        a_arr[0] = 8'd1; a_arr[1] = 8'd2; a_arr[2] = 8'd3; a_arr[3] = 8'd4;
        b_arr[0] = 8'd5; b_arr[1] = 8'd6; b_arr[2] = 8'd7; b_arr[3] = 8'd8;
        run_cmd(4, 0, 0);
        chk("t1_sum70", 32'(last_res), 32'd70);

        // 2: same vectors with three stall cycles between beats
        run_cmd(4, 1, 0);
        chk("t2_sum70", 32'(last_res), 32'd70);

        // 3: empty command
        run_cmd(0, 0, 0);
        chk("t3_sum0", 32'(last_res), 32'd0);

        // 4: wrap-around
        a_arr[0] = 8'd255; a_arr[1] = 8'd255;
        b_arr[0] = 8'd255; b_arr[1] = 8'd255;
        run_cmd(2, 0, 0);
        chk("t4_wrap", 32'(last_res), 32'd64514);

        // 5: result held 5 cycles with a stray start, then back-to-back len=1
        a_arr[0] = 8'd200; a_arr[1] = 8'd100; b_arr[0] = 8'd150; b_arr[1] = 8'd90;
        run_cmd(2, 0, 5);
        a_arr[0] = 8'd3; b_arr[0] = 8'd4;
        run_cmd(1, 0, 0);
        chk("t5_sum12", 32'(last_res), 32'd12);

        // 6: reset after 2 of 4 beats
        start = 1'b1;
        len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a = 8'(i + 7);
            in_b = 8'(i + 9);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_res_data", 32'(res_data), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        a_arr[0] = 8'd2; a_arr[1] = 8'd3; b_arr[0] = 8'd10; b_arr[1] = 8'd10;
        run_cmd(2, 0, 0);
        chk("t6_sum50", 32'(last_res), 32'd50);

        // Randomized commands with random stalls and result back-pressure
        for (int k = 0; k < 25; k++) begin
            int n;
            n = $urandom_range(0, 16);
            for (int i = 0; i < n; i++) begin
                a_arr[i] = 8'($urandom);
                b_arr[i] = 8'($urandom);
            end
            run_cmd(n, ($urandom_range(0, 1) == 1) ? 2 : 0, $urandom_range(0, 3));
        end

        // Maximum length, all-ones operands followed by random ones
        for (int i = 0; i < 255; i++) begin
            a_arr[i] = (i < 8) ? 8'd255 : 8'($urandom);
            b_arr[i] = (i < 8) ? 8'd255 : 8'($urandom);
        end
        run_cmd(255, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
